// File: rtl/state_dump_unit_if.sv
// Nibble stream port of the state dump unit: ready/valid handshake carrying one
// 4-bit nibble per transfer. The dump unit is the master, the consumer the slave.
interface state_dump_unit_if;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/state_dump_unit.sv
// Run monitor and state dumper for the 4004-style test system. Watches the
// sampled PC once per instruction cycle, detects end-of-program, self-loop
// stall or instruction timeout, freezes the CPU and streams a reason header,
// the halted PC and every architectural state nibble over a ready/valid port.
module state_dump_unit #(
  parameter int PC_WIDTH     = 12,
  parameter int END_PC       = 256,
  parameter int NUM_REGS     = 16,
  parameter int RAM_WORDS    = 64,
  parameter int STATUS_WORDS = 16,
  parameter int STALL_LIMIT  = 256,
  parameter int MAX_INSNS    = 65535,
  localparam int TOTAL       = 2 + NUM_REGS + RAM_WORDS + STATUS_WORDS,
  localparam int AW          = $clog2(TOTAL)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic                sync,
  input  logic [PC_WIDTH-1:0] pc,
  output logic                cpu_hold,
  output logic [AW-1:0]       dbg_addr,
  input  logic [3:0]          dbg_data,
  state_dump_unit_if.master   strm,
  output logic                busy,
  output logic                done,
  output logic [1:0]          reason
);

  localparam int NPC = PC_WIDTH / 4;
  localparam int PIW = (NPC > 1) ? $clog2(NPC) : 1;
  localparam int IW  = $clog2(MAX_INSNS + 1);
  localparam int SW  = $clog2(STALL_LIMIT + 1);

  localparam logic [IW-1:0]     INSN_MAX  = IW'(MAX_INSNS);
  localparam logic [SW-1:0]     STALL_MAX = SW'(STALL_LIMIT);
  localparam logic [PC_WIDTH:0] END_C     = (PC_WIDTH + 1)'(END_PC);
  localparam logic [AW-1:0]     LAST_ADDR = AW'(TOTAL - 1);
  localparam logic [PIW-1:0]    PC_TOP    = PIW'(NPC - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RUN   = 3'd1;
  localparam logic [2:0] HDR   = 3'd2;
  localparam logic [2:0] PCN   = 3'd3;
  localparam logic [2:0] FETCH = 3'd4;
  localparam logic [2:0] SEND  = 3'd5;
  localparam logic [2:0] DONE  = 3'd6;

  logic [1:0]          rst_sync;
  logic                rst_n_int;
  logic [2:0]          state;
  logic [IW-1:0]       insn_count;
  logic [SW-1:0]       stall_count;
  logic [PC_WIDTH-1:0] last_pc;
  logic [PC_WIDTH-1:0] pc_q;
  logic                first_q;
  logic                hdr_idx;
  logic [PIW-1:0]      pc_idx;
  logic                vld_q;
  logic                cap_q;
  logic [3:0]          data_q;

  logic                rep;
  logic [IW-1:0]       insn_nxt;
  logic [SW-1:0]       stall_nxt;
  logic [1:0]          halt_rsn;
  logic [3:0]          data_mux;

  // Nibble i of the halted PC, nibble 0 being the least significant.
  function automatic logic [3:0] pc_nib(input logic [PC_WIDTH-1:0] p,
                                        input logic [PIW-1:0] i);
    logic [PC_WIDTH-1:0] sh;
    sh = p >> (4 * i);
    return sh[3:0];
  endfunction

  // Reset asserts immediately and releases two clock edges after reset_n rises.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n_int = rst_sync[1];

  // Counter updates and halt decision for the current sync sample.
  always_comb begin
    rep      = !first_q && (pc == last_pc);
    insn_nxt = (insn_count == INSN_MAX) ? insn_count : insn_count + 1'b1;
    if (!rep)                         stall_nxt = '0;
    else if (stall_count == STALL_MAX) stall_nxt = stall_count;
    else                              stall_nxt = stall_count + 1'b1;
    if ({1'b0, pc} >= END_C)          halt_rsn = 2'd1;
    else if (stall_nxt == STALL_MAX)  halt_rsn = 2'd2;
    else if (insn_nxt == INSN_MAX)    halt_rsn = 2'd3;
    else                              halt_rsn = 2'd0;
  end

  // The first SEND cycle presents the read data directly so a state nibble
  // costs only FETCH + SEND; after that the captured copy keeps it stable.
  assign data_mux       = (state == SEND && !cap_q) ? dbg_data : data_q;
  assign strm.out_data  = data_mux;
  assign strm.out_valid = vld_q || (state == SEND);
  assign busy           = (state != IDLE) && (state != DONE);
  assign done           = (state == DONE);

  // Run monitoring and dump sequencing; start re-arms from any state.
  always_ff @(posedge clock or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state       <= IDLE;
      insn_count  <= '0;
      stall_count <= '0;
      last_pc     <= '0;
      pc_q        <= '0;
      first_q     <= 1'b0;
      hdr_idx     <= 1'b0;
      pc_idx      <= '0;
      vld_q       <= 1'b0;
      cap_q       <= 1'b0;
      data_q      <= '0;
      dbg_addr    <= '0;
      cpu_hold    <= 1'b0;
      reason      <= 2'd0;
    end else if (start) begin
      state       <= RUN;
      insn_count  <= '0;
      stall_count <= '0;
      first_q     <= 1'b1;
      vld_q       <= 1'b0;
      cap_q       <= 1'b0;
      cpu_hold    <= 1'b0;
      reason      <= 2'd0;
    end else begin
      case (state)
        RUN: begin
          if (sync) begin
            insn_count  <= insn_nxt;
            stall_count <= stall_nxt;
            last_pc     <= pc;
            first_q     <= 1'b0;
            if (halt_rsn != 2'd0) begin
              reason   <= halt_rsn;
              pc_q     <= pc;
              cpu_hold <= 1'b1;
              hdr_idx  <= 1'b0;
              state    <= HDR;
            end
          end
        end
        HDR: begin
          if (!vld_q) begin
            vld_q  <= 1'b1;
            data_q <= 4'hA;
          end else if (strm.out_ready) begin
            if (!hdr_idx) begin
              hdr_idx <= 1'b1;
              data_q  <= {2'b00, reason};
            end else begin
              pc_idx <= PC_TOP;
              data_q <= pc_nib(pc_q, PC_TOP);
              state  <= PCN;
            end
          end
        end
        PCN: begin
          if (strm.out_ready) begin
            if (pc_idx == '0) begin
              vld_q    <= 1'b0;
              dbg_addr <= '0;
              state    <= FETCH;
            end else begin
              pc_idx <= pc_idx - 1'b1;
              data_q <= pc_nib(pc_q, pc_idx - 1'b1);
            end
          end
        end
        FETCH: begin
          cap_q <= 1'b0;
          state <= SEND;
        end
        SEND: begin
          data_q <= data_mux;
          if (strm.out_ready) begin
            cap_q <= 1'b0;
            if (dbg_addr == LAST_ADDR) begin
              state <= DONE;
            end else begin
              dbg_addr <= dbg_addr + 1'b1;
              state    <= FETCH;
            end
          end else begin
            cap_q <= 1'b1;
          end
        end
        IDLE, DONE: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_state_dump_unit.sv
// Bench for state_dump_unit: drives PC sequences, predicts the halt point and
// reason from the halt rules, and compares the delivered nibble stream with the
// expected header, PC and model state memory.
module tb_state_dump_unit;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        sync;
  logic [11:0] pc;
  logic        hold_a, busy_a, done_a;
  logic        hold_b, busy_b, done_b;
  logic [1:0]  reason_a, reason_b;
  logic [6:0]  dbg_addr_a, dbg_addr_b;
  logic [3:0]  dbg_data_a, dbg_data_b;
  logic [3:0]  mem [128];
  logic        bp;
  logic        prev_stall;
  logic [3:0]  prev_dat;
  logic [3:0]  rx [$];
  int          seq [$];
  int          n_chk;
  int          n_err;

  state_dump_unit_if if_a ();
  state_dump_unit_if if_b ();

  state_dump_unit u_dut_a (
    .clock(clock), .reset_n(reset_n), .start(start), .sync(sync), .pc(pc),
    .cpu_hold(hold_a), .dbg_addr(dbg_addr_a), .dbg_data(dbg_data_a),
    .strm(if_a), .busy(busy_a), .done(done_a), .reason(reason_a)
  );

  state_dump_unit #(.MAX_INSNS(16), .STALL_LIMIT(4)) u_dut_b (
    .clock(clock), .reset_n(reset_n), .start(start), .sync(sync), .pc(pc),
    .cpu_hold(hold_b), .dbg_addr(dbg_addr_b), .dbg_data(dbg_data_b),
    .strm(if_b), .busy(busy_b), .done(done_b), .reason(reason_b)
  );

  initial clock = 1'b0;
  initial forever #5 clock = ~clock;

  // State memory with a one-cycle read latency.
  always @(posedge clock) begin
    dbg_data_a <= mem[dbg_addr_a];
    dbg_data_b <= mem[dbg_addr_b];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Halt index and reason from the halt rules applied to the whole sequence.
  function automatic int exp_halt(input int endpc, input int stall_lim,
                                  input int max_insns, output int rsn);
    for (int i = 0; i < seq.size(); i++) begin
      bit e, s, t;
      e = seq[i] >= endpc;
      s = 1'b0;
      if (i >= stall_lim) begin
        s = 1'b1;
        for (int j = 1; j <= stall_lim; j++)
          if (seq[i-j] != seq[i]) s = 1'b0;
      end
      t = (i + 1) >= max_insns;
      if (e || s || t) begin
        rsn = e ? 1 : (s ? 2 : 3);
        return i;
      end
    end
    rsn = 0;
    return -1;
  endfunction

  initial forever begin
    @(posedge clock);
    #1;
    if_a.out_ready = bp ? ($urandom_range(0, 99) < 30) : 1'b1;
    if_b.out_ready = 1'b1;
  end

  initial forever begin
    @(negedge clock);
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stable_vld", 32'(if_a.out_valid), 32'd1);
        chk("stable_dat", 32'(if_a.out_data), 32'(prev_dat));
      end
      if (if_a.out_valid && if_a.out_ready) rx.push_back(if_a.out_data);
      prev_stall = if_a.out_valid && !if_a.out_ready;
      prev_dat   = if_a.out_data;
    end
  end

  task automatic run_test(input bit use_bp);
    int ia, ra, rb, cnt;
    logic [3:0] exp_q [$];
    ia = exp_halt(256, 256, 65535, ra);
    void'(exp_halt(256, 4, 16, rb));
    if (ia < 0) begin
      $display("FAIL model: sequence never halts");
      $fatal(1);
    end
    bp = use_bp;
    start = 1'b1;
    rx.delete();
    prev_stall = 1'b0;
    tick();
    start = 1'b0;
    chk("start_done", 32'(done_a), 32'd0);
    chk("start_hold", 32'(hold_a), 32'd0);
    chk("start_busy", 32'(busy_a), 32'd1);
    chk("start_rsn", 32'(reason_a), 32'd0);
    chk("start_vld", 32'(if_a.out_valid), 32'd0);
    for (int i = 0; i <= ia; i++) begin
      repeat ($urandom_range(0, 2)) begin
        sync = 1'b0;
        pc = 12'($urandom);
        tick();
      end
      sync = 1'b1;
      pc = 12'(seq[i]);
      if (i == ia) chk("pre_hold", 32'(hold_a), 32'd0);
      tick();
    end
    sync = 1'b0;
    chk("halt_hold", 32'(hold_a), 32'd1);
    chk("halt_rsn", 32'(reason_a), 32'(ra));
    chk("halt_vld", 32'(if_a.out_valid), 32'd0);
    tick();
    chk("hdr_vld", 32'(if_a.out_valid), 32'd1);
    chk("hdr_dat", 32'(if_a.out_data), 32'hA);
    cnt = 0;
    while (!done_a && cnt < 3000) begin
      tick();
      cnt++;
    end
    chk("done_wait", 32'(done_a), 32'd1);
    if (!use_bp) chk("thruput", 32'(cnt), 32'd201);
    exp_q.push_back(4'hA);
    exp_q.push_back(4'(ra));
    for (int k = 2; k >= 0; k--) exp_q.push_back(4'(seq[ia] >> (4 * k)));
    for (int a = 0; a < 98; a++) exp_q.push_back(mem[a]);
    chk("stream_len", 32'(rx.size()), 32'd103);
    for (int k = 0; k < 103; k++)
      chk($sformatf("nib%0d", k), (k < rx.size()) ? 32'(rx[k]) : 32'hDEAD, 32'(exp_q[k]));
    chk("end_vld", 32'(if_a.out_valid), 32'd0);
    chk("end_hold", 32'(hold_a), 32'd1);
    chk("end_busy", 32'(busy_a), 32'd0);
    chk("b_done", 32'(done_b), 32'd1);
    chk("b_rsn", 32'(reason_b), 32'(rb));
  endtask

  task automatic seq_ramp(input int lo, input int hi);
    seq.delete();
    for (int v = lo; v <= hi; v++) seq.push_back(v);
  endtask

  task automatic seq_random();
    int p;
    seq.delete();
    p = $urandom_range(0, 255);
    for (int n = 0; n < 50; n++) begin
      if ($urandom_range(0, 9) >= 3) p = $urandom_range(0, 255);
      seq.push_back(p);
    end
    seq.push_back($urandom_range(256, 4095));
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset_n = 1'b0;
    start = 1'b0;
    sync = 1'b0;
    pc = '0;
    bp = 1'b0;
    prev_stall = 1'b0;
    if_a.out_ready = 1'b1;
    if_b.out_ready = 1'b1;
    for (int a = 0; a < 128; a++) mem[a] = 4'($urandom);
    mem[0] = 4'h5;
    mem[1] = 4'h1;
    for (int i = 0; i < 64; i++) mem[18 + i] = 4'(i);

    repeat (3) tick();
    chk("rst_hold", 32'(hold_a), 32'd0);
    chk("rst_vld", 32'(if_a.out_valid), 32'd0);
    chk("rst_dat", 32'(if_a.out_data), 32'd0);
    chk("rst_addr", 32'(dbg_addr_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_rsn", 32'(reason_a), 32'd0);
    reset_n = 1'b1;
    repeat (4) tick();

    // Normal end, then the same run again from DONE.
    seq_ramp(0, 256);
    run_test(1'b0);
    run_test(1'b0);

    // Stall on a self-loop at 0x023.
    seq.delete();
    seq.push_back(12'h020);
    seq.push_back(12'h021);
    repeat (257) seq.push_back(12'h023);
    run_test(1'b0);

    // Stall and timeout together on the short-limit instance.
    seq_ramp(0, 10);
    repeat (5) seq.push_back(12);
    seq.push_back(256);
    run_test(1'b0);

    // First sync after start equals the previous run's last pc.
    seq.delete();
    repeat (4) seq.push_back(12);
    seq.push_back(20);
    seq.push_back(21);
    seq.push_back(22);
    seq.push_back(256);
    run_test(1'b0);

    // End and timeout together, then a pure timeout on the short-limit instance.
    seq_ramp(0, 14);
    seq.push_back(256);
    run_test(1'b0);
    seq_ramp(0, 15);
    seq.push_back(256);
    run_test(1'b0);

    // Random PC traffic under backpressure.
    repeat (2) begin
      seq_random();
      run_test(1'b1);
    end

    // Reset in the middle of the stream, then a fresh complete run.
    bp = 1'b0;
    start = 1'b1;
    rx.delete();
    prev_stall = 1'b0;
    tick();
    start = 1'b0;
    sync = 1'b1;
    pc = 12'h100;
    tick();
    sync = 1'b0;
    for (int c = 0; c < 500 && rx.size() < 40; c++) tick();
    chk("mid_reach40", 32'(rx.size() >= 40), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_hold", 32'(hold_a), 32'd0);
    chk("mid_vld", 32'(if_a.out_valid), 32'd0);
    chk("mid_dat", 32'(if_a.out_data), 32'd0);
    chk("mid_addr", 32'(dbg_addr_a), 32'd0);
    chk("mid_busy", 32'(busy_a), 32'd0);
    chk("mid_done", 32'(done_a), 32'd0);
    chk("mid_rsn", 32'(reason_a), 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (4) tick();
    chk("post_rst_busy", 32'(busy_a), 32'd0);
    seq_ramp(0, 256);
    run_test(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
